// File: rtl/harness_pkg.sv
// harness_pkg
//   Types and helpers shared by the run sequencer, its per-channel edge
//   counter and any bench or board wrapper that decodes the verdict.
//
//   harness_state_e   : sequencer states (HOLD, RUN and the three terminal states)
//   harness_verdict_e : one-hot encoding of {pass, fail, timeout}; NONE while
//                       not in a terminal state
//   cnt_width()       : bits needed to count 0 .. n-1 (never less than 1)
//   verdict_of()      : verdict presented for a given state
package harness_pkg;

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } harness_state_e;

  // Bit order matches the output concatenation {pass, fail, timeout}.
  typedef enum logic [2:0] {
    VERDICT_NONE    = 3'b000,
    VERDICT_TIMEOUT = 3'b001,
    VERDICT_FAIL    = 3'b010,
    VERDICT_PASS    = 3'b100
  } harness_verdict_e;

  // Width of a counter that must represent the values 0 .. n-1.
  function automatic int cnt_width(input int n);
    int w;
    if (n <= 2) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

  function automatic harness_verdict_e verdict_of(input harness_state_e s);
    harness_verdict_e v;
    case (s)
      S_PASS:    v = VERDICT_PASS;
      S_FAIL:    v = VERDICT_FAIL;
      S_TIMEOUT: v = VERDICT_TIMEOUT;
      default:   v = VERDICT_NONE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/edge_toggle_counter.sv
// edge_toggle_counter
//   Activity monitor for one DUT status line. Counts edges (either
//   direction) while enabled, saturating at MIN_TOGGLES, and raises a
//   registered 'seen' flag once the count reaches MIN_TOGGLES.
//
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (clears everything)
//   en_i   : count edges this cycle
//   clr_i  : clear the toggle count and the seen flag
//   ch_i   : monitored status line, synchronous to clk_i
//   seen_o : channel has reached MIN_TOGGLES edges
module edge_toggle_counter
  import harness_pkg::*;
#(
  parameter int MIN_TOGGLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  input  logic ch_i,
  output logic seen_o
);

  localparam int             TW      = cnt_width(MIN_TOGGLES + 1);
  localparam logic [TW-1:0]  TOG_MAX = TW'(MIN_TOGGLES);

  logic          prev_q;
  logic [TW-1:0] tog_q, tog_d;
  logic          seen_q, seen_d;
  logic          ch_edge;

  // prev_q follows the line every cycle, including while counting is
  // disabled, so the first enabled cycle compares against a fresh value.
  assign ch_edge = ch_i ^ prev_q;

  always_comb begin
    tog_d = tog_q;
    if (clr_i) begin
      tog_d = '0;
    end else if (en_i && ch_edge && (tog_q != TOG_MAX)) begin
      tog_d = tog_q + TW'(1);
    end
    // Flag is derived from the next count so it appears one cycle after
    // the completing edge rather than two.
    seen_d = (tog_d == TOG_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
      tog_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      prev_q <= ch_i;
      tog_q  <= tog_d;
      seen_q <= seen_d;
    end
  end

  assign seen_o = seen_q;

endmodule

// File: rtl/harness_run_sequencer.sv
// harness_run_sequencer
//   Run controller for board-level simulation / on-FPGA self-test. Holds the
//   DUT in reset for RESET_CYCLES cycles, then runs it, watching NUM_CH status
//   lines for activity and fail_in for a trap. Ends in exactly one verdict:
//   PASS (every channel toggled MIN_TOGGLES times), FAIL (fail_in seen) or
//   TIMEOUT (TIMEOUT_CYCLES run cycles elapsed). A restart pulse in a
//   terminal state starts a fresh run.
//
//   clock       : single clock
//   reset       : synchronous active-high reset of the whole block
//   restart     : pulse, honoured only in PASS/FAIL/TIMEOUT
//   fail_in     : DUT error indication, only looked at in RUN
//   ch_in       : DUT status lines
//   dut_reset   : active-high reset to the DUT (high in HOLD)
//   running     : high in RUN
//   done        : high in any terminal state
//   pass/fail/timeout : one-hot verdict, valid while done
//   cycle_count : RUN cycles elapsed (0 on first RUN cycle)
//   ch_seen     : per-channel "reached MIN_TOGGLES" flags
module harness_run_sequencer
  import harness_pkg::*;
#(
  parameter int RESET_CYCLES   = 10,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int NUM_CH         = 4,
  parameter int MIN_TOGGLES    = 2,
  parameter int CNT_W          = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              restart,
  input  logic              fail_in,
  input  logic [NUM_CH-1:0] ch_in,
  output logic              dut_reset,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [NUM_CH-1:0] ch_seen
);

  localparam int                HOLD_W    = cnt_width(RESET_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  harness_state_e     state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic [NUM_CH-1:0]  seen;
  logic               all_seen;
  logic               count_en;
  logic               count_clr;
  harness_verdict_e   verdict;

  assign all_seen = &seen;

  // ---------------------------------------------------------------------
  // State register and counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_HOLD;
      hold_cnt_q    <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state. Exits from RUN use the registered flags and counter, with
  // priority FAIL > PASS > TIMEOUT. The cycle counter only advances when the
  // block stays in RUN, so the value frozen in a terminal state is the one
  // that was visible on the last RUN cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = '0;
    cycle_count_d = cycle_count_q;
    case (state_q)
      S_HOLD: begin
        cycle_count_d = '0;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (fail_in) begin
          state_d = S_FAIL;
        end else if (all_seen) begin
          state_d = S_PASS;
        end else if (cycle_count_q == RUN_LAST) begin
          state_d = S_TIMEOUT;
        end else begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
        end
      end
      S_PASS, S_FAIL, S_TIMEOUT: begin
        if (restart) begin
          state_d       = S_HOLD;
          cycle_count_d = '0;
        end
      end
      default: begin
        state_d       = S_HOLD;
        cycle_count_d = '0;
      end
    endcase
  end

  // Edges are counted only on cycles that remain in RUN (same freeze rule as
  // the cycle counter). Clearing is tied to entering/staying in HOLD so that
  // ch_seen drops on the same edge dut_reset rises after a restart.
  assign count_en  = (state_q == S_RUN) && (state_d == S_RUN);
  assign count_clr = (state_d == S_HOLD);

  // ---------------------------------------------------------------------
  // Per-channel activity monitors
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      edge_toggle_counter #(
        .MIN_TOGGLES(MIN_TOGGLES)
      ) u_edge_cnt (
        .clk_i (clock),
        .rst_i (reset),
        .en_i  (count_en),
        .clr_i (count_clr),
        .ch_i  (ch_in[gi]),
        .seen_o(seen[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Outputs: pure decodes of registers, so they change on the state edge.
  // ---------------------------------------------------------------------
  always_comb begin
    verdict                = verdict_of(state_q);
    {pass, fail, timeout}  = verdict;
    done                   = (verdict != VERDICT_NONE);
    dut_reset              = (state_q == S_HOLD);
    running                = (state_q == S_RUN);
  end

  assign cycle_count = cycle_count_q;
  assign ch_seen     = seen;

endmodule

// File: tb/tb_harness_run_sequencer.sv
module tb_harness_run_sequencer;
  import harness_pkg::*;

  localparam int RESET_CYCLES   = 10;
  localparam int TIMEOUT_CYCLES = 10000;
  localparam int NUM_CH         = 4;
  localparam int MIN_TOGGLES    = 2;
  localparam int CNT_W          = 32;
  localparam logic [NUM_CH-1:0] ALL1 = '1;

  logic              clock = 1'b0;
  logic              reset;
  logic              restart;
  logic              fail_in;
  logic [NUM_CH-1:0] ch_in;
  logic              dut_reset, running, done, pass, fail, timeout;
  logic [CNT_W-1:0]  cycle_count;
  logic [NUM_CH-1:0] ch_seen;

  harness_run_sequencer #(
    .RESET_CYCLES  (RESET_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .NUM_CH        (NUM_CH),
    .MIN_TOGGLES   (MIN_TOGGLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .restart    (restart),
    .fail_in    (fail_in),
    .ch_in      (ch_in),
    .dut_reset  (dut_reset),
    .running    (running),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .cycle_count(cycle_count),
    .ch_seen    (ch_seen)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: run phase, elapsed run cycles and edge tallies per
  // channel, advanced once per clock from the rules of the run controller.
  // ---------------------------------------------------------------------
  localparam int M_HOLD = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3, M_TMO = 4;
  int                m_state = M_HOLD;
  int                m_hold  = 0;
  int                m_cyc   = 0;
  int                m_tog [NUM_CH];
  logic [NUM_CH-1:0] m_prev  = '0;

  task automatic model_clear_tallies();
    for (int i = 0; i < NUM_CH; i++) m_tog[i] = 0;
  endtask

  task automatic model_step();
    bit all_seen;
    if (reset) begin
      m_state = M_HOLD; m_hold = 0; m_cyc = 0; m_prev = '0;
      model_clear_tallies();
      return;
    end
    case (m_state)
      M_HOLD: begin
        if (m_hold == RESET_CYCLES - 1) begin m_state = M_RUN; m_hold = 0; end
        else m_hold++;
      end
      M_RUN: begin
        all_seen = 1'b1;
        for (int i = 0; i < NUM_CH; i++) if (m_tog[i] < MIN_TOGGLES) all_seen = 1'b0;
        if (fail_in)                             m_state = M_FAIL;
        else if (all_seen)                       m_state = M_PASS;
        else if (m_cyc == TIMEOUT_CYCLES - 1)    m_state = M_TMO;
        else begin
          m_cyc++;
          for (int i = 0; i < NUM_CH; i++)
            if (ch_in[i] != m_prev[i] && m_tog[i] < MIN_TOGGLES) m_tog[i]++;
        end
      end
      default: begin
        if (restart) begin
          m_state = M_HOLD; m_cyc = 0;
          model_clear_tallies();
        end
      end
    endcase
    m_prev = ch_in;
  endtask

  task automatic model_check();
    logic [5:0]        exp_ctrl;
    logic [NUM_CH-1:0] exp_seen;
    exp_ctrl = {m_state == M_HOLD, m_state == M_RUN, m_state >= M_PASS,
                m_state == M_PASS, m_state == M_FAIL, m_state == M_TMO};
    for (int i = 0; i < NUM_CH; i++) exp_seen[i] = (m_tog[i] == MIN_TOGGLES);
    chk("model_ctrl", {58'd0, dut_reset, running, done, pass, fail, timeout}, {58'd0, exp_ctrl});
    chk("model_count", {32'd0, cycle_count}, 64'(m_cyc));
    chk("model_seen", {60'd0, ch_seen}, {60'd0, exp_seen});
  endtask

  // Inputs change at the falling edge; the model steps on the rising edge
  // and outputs are compared at the next falling edge.
  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    model_check();
  endtask

  // Count cycles until running rises (current cycle is HOLD cycle 0).
  task automatic hold_phase(input bit fail0, input bit restart3, output int len);
    len = 0;
    while (!running && len < 100) begin
      fail_in = fail0 && (len == 0);
      restart = restart3 && (len == 3);
      tick();
      len++;
    end
    fail_in = 1'b0;
    restart = 1'b0;
  endtask

  // Drive a run starting at RUN cycle 0; returns the RUN-relative cycle at
  // which done is first observed (-1 if the bound expired or reset fired).
  task automatic run_phase(input logic [NUM_CH-1:0] init, input int t1, input int t2,
                           input int fail_at, input int restart_at, input int rst_at,
                           output int done_at);
    logic [NUM_CH-1:0] ch;
    done_at = -1;
    for (int k = 0; k < TIMEOUT_CYCLES + 50; k++) begin
      if (done) begin done_at = k; break; end
      ch = init;
      if (t1 >= 0 && k >= t1) ch = ch ^ ALL1;
      if (t2 >= 0 && k >= t2) ch = ch ^ ALL1;
      ch_in   = ch;
      fail_in = (k == fail_at);
      restart = (k == restart_at);
      reset   = (k == rst_at);
      tick();
      if (k == rst_at) begin
        reset = 1'b0; fail_in = 1'b0; restart = 1'b0;
        return;
      end
    end
    fail_in = 1'b0;
    restart = 1'b0;
  endtask

  typedef struct {
    string             name;
    logic [NUM_CH-1:0] init;
    int                t1;
    int                t2;
    int                fail_at;
    bit                fail_hold;
    harness_verdict_e  exp_v;
    int                exp_cnt;
    logic [NUM_CH-1:0] exp_seen;
    int                exp_done;
  } vec_t;

  vec_t vecs [7];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int hold_len, done_at, runs;
    bit prev_done;

    //               name            init t1  t2  fail fh verdict          cnt   seen done
    vecs[0] = '{"timeout_idle",  4'h0, -1, -1, -1,  0, VERDICT_TIMEOUT, 9999, 4'h0, 10000};
    vecs[1] = '{"pass_at_50",    4'h0, 30, 50, -1,  0, VERDICT_PASS,      51, 4'hF,    52};
    vecs[2] = '{"fail_beats_pass",4'h0, 10, 20, 20, 1, VERDICT_FAIL,      20, 4'h0,    21};
    vecs[3] = '{"ch_high_idle",  4'hF, -1, -1, -1,  0, VERDICT_TIMEOUT, 9999, 4'h0, 10000};
    vecs[4] = '{"fail_first",    4'h0, -1, -1,  0,  0, VERDICT_FAIL,       0, 4'h0,     1};
    vecs[5] = '{"partial_fail",  4'h0,  5, -1, 100, 0, VERDICT_FAIL,     100, 4'h0,   101};
    vecs[6] = '{"fast_pass",     4'h0,  0,  1, -1,  0, VERDICT_PASS,       2, 4'hF,     3};

    reset = 1'b1; restart = 1'b0; fail_in = 1'b0; ch_in = '0;
    tick();
    chk("reset_state", {32'd0, dut_reset, running, done, pass, fail, timeout, ch_seen, 22'd0},
        {32'd0, 6'b100000, 4'h0, 22'd0});

    for (int v = 0; v < 7; v++) begin
      reset = 1'b1; ch_in = vecs[v].init;
      tick(); tick();
      reset = 1'b0;
      hold_phase(vecs[v].fail_hold, 1'b0, hold_len);
      chk({vecs[v].name, "_hold_len"}, 64'(hold_len), 64'(RESET_CYCLES));
      run_phase(vecs[v].init, vecs[v].t1, vecs[v].t2, vecs[v].fail_at, -1, -1, done_at);
      chk({vecs[v].name, "_done_at"}, 64'(done_at), 64'(vecs[v].exp_done));
      chk({vecs[v].name, "_verdict"}, {61'd0, pass, fail, timeout}, {61'd0, vecs[v].exp_v});
      chk({vecs[v].name, "_count"}, {32'd0, cycle_count}, 64'(vecs[v].exp_cnt));
      chk({vecs[v].name, "_seen"}, {60'd0, ch_seen}, {60'd0, vecs[v].exp_seen});
      $display("vec %0d %s: verdict=%b count=%0d seen=%h done_at=%0d hold=%0d",
               v, vecs[v].name, {pass, fail, timeout}, cycle_count, ch_seen, done_at, hold_len);
    end

    // Restart: ignored in HOLD and RUN, honoured after PASS.
    reset = 1'b1; ch_in = '0;
    tick(); tick();
    reset = 1'b0;
    hold_phase(1'b0, 1'b1, hold_len);
    chk("rs_hold_len", 64'(hold_len), 64'(RESET_CYCLES));
    run_phase('0, 30, 50, -1, 10, -1, done_at);
    chk("rs_first_pass_at", 64'(done_at), 64'd52);
    chk("rs_first_pass", {63'd0, pass}, 64'd1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_dut_reset", {63'd0, dut_reset}, 64'd1);
    chk("rs_done", {63'd0, done}, 64'd0);
    chk("rs_count", {32'd0, cycle_count}, 64'd0);
    chk("rs_seen", {60'd0, ch_seen}, 64'd0);
    hold_phase(1'b0, 1'b0, hold_len);
    chk("rs_hold_len2", 64'(hold_len), 64'(RESET_CYCLES));
    run_phase('0, 30, 50, -1, -1, -1, done_at);
    chk("rs_second_pass_at", 64'(done_at), 64'd52);
    chk("rs_second_count", {32'd0, cycle_count}, 64'd51);
    $display("restart seq: second run verdict=%b count=%0d", {pass, fail, timeout}, cycle_count);

    // Reset pulse at RUN cycle 500.
    reset = 1'b1; ch_in = '0;
    tick(); tick();
    reset = 1'b0;
    hold_phase(1'b0, 1'b0, hold_len);
    run_phase('0, 100, -1, -1, -1, 500, done_at);
    chk("mr_outputs", {58'd0, dut_reset, running, done, pass, fail, timeout}, {58'd0, 6'b100000});
    chk("mr_count", {32'd0, cycle_count}, 64'd0);
    chk("mr_seen", {60'd0, ch_seen}, 64'd0);
    hold_phase(1'b0, 1'b0, hold_len);
    chk("mr_hold_len", 64'(hold_len), 64'(RESET_CYCLES));
    run_phase('0, -1, -1, 5, -1, -1, done_at);
    chk("mr_fail_at", 64'(done_at), 64'd6);
    $display("mid-run reset seq: hold=%0d verdict=%b", hold_len, {pass, fail, timeout});

    // Randomized traffic checked cycle by cycle against the model.
    runs = 0;
    prev_done = done;
    for (int c = 0; c < 4000; c++) begin
      reset   = ($urandom_range(0, 1999) == 0);
      restart = ($urandom_range(0, 5) == 0);
      fail_in = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 29) == 0) ch_in[i] = ~ch_in[i];
      tick();
      if (done && !prev_done) begin
        runs++;
        $display("random run %0d: verdict=%b count=%0d seen=%h", runs, {pass, fail, timeout},
                 cycle_count, ch_seen);
      end
      prev_done = done;
    end
    reset = 1'b0; restart = 1'b0; fail_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/harness_run_sequencer.md
# harness_run_sequencer

Parametrised, synthesizable run controller for board-level simulation and on-FPGA self-test. It holds the DUT in reset for a programmable number of cycles, then counts run cycles. It monitors NUM_CH DUT status lines (LEDs, GPIO) for activity and issues a single verdict: pass, fail or timeout. It sits between the top-level clock/reset and the DUT; the bench or a board wrapper reads the verdict instead of hard-coding fixed reset and run delays.

## Interface
Parameters:
- RESET_CYCLES, default 10: cycles `dut_reset` stays asserted after each start; legal range ≥ 1.
- TIMEOUT_CYCLES, default 10000: maximum RUN cycles before a timeout verdict; legal range ≥ 1.
- NUM_CH, default 4: number of monitored status channels.
- MIN_TOGGLES, default 2: edges (either direction) each channel needs for a pass; legal range ≥ 1.
- CNT_W, default 32: width of `cycle_count`; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clock`  in  1: single clock for the whole block.
- `reset`  in  1: synchronous, active-high; resets every register of the block.
- `restart`  in  1: single-cycle pulse; honoured only in a terminal state.
- `fail_in`  in  1: DUT trap/error; sampled only in RUN.
- `ch_in`  in  NUM_CH: DUT status lines, synchronous to `clock`.
- `dut_reset`  out  1: active-high reset to the DUT. The wrapper inverts it for active-low DUT pins.
- `running`  out  1: high in RUN.
- `done`  out  1: high in any terminal state.
- `pass`, `fail`, `timeout`  out  1 each: one-hot verdict, valid while `done` is high.
- `cycle_count`  out  CNT_W: RUN cycles elapsed.
- `ch_seen`  out  NUM_CH: bit i set once channel i has reached MIN_TOGGLES.

## Operation
- States: HOLD, RUN, PASS, FAIL, TIMEOUT.
- On reset: state HOLD, hold counter 0, `dut_reset`=1, `cycle_count`=0, all toggle counters 0, `ch_seen`=0, and `running`, `done`, `pass`, `fail`, `timeout` all 0.
- HOLD:
  - `dut_reset`=1; the hold counter increments each cycle.
  - When the counter reaches RESET_CYCLES-1, the next state is RUN.
  - Toggle counters and `cycle_count` are held at 0.
  - The previous-value register for `ch_in` tracks the input every cycle, so entering RUN never produces a spurious edge.
- RUN:
  - `dut_reset`=0; `cycle_count` increments every cycle.
  - Per channel: an edge is `ch_in[i] != prev[i]`. Each edge increments the channel's toggle counter, which saturates at MIN_TOGGLES and is ceil(log2(MIN_TOGGLES+1)) bits wide.
  - `ch_seen[i]` = (counter == MIN_TOGGLES), registered.
- RUN exit, evaluated on the registered values each cycle with priority FAIL > PASS > TIMEOUT:
  - `fail_in`=1 → FAIL.
  - All `ch_seen` bits = 1 → PASS.
  - `cycle_count` == TIMEOUT_CYCLES-1 → TIMEOUT.
- Terminal states (PASS, FAIL, TIMEOUT):
  - Outputs are frozen: `cycle_count`, `ch_seen` and the verdict hold.
  - `dut_reset`=0, so the DUT state stays observable.
  - `restart`=1 → HOLD: counters and `ch_seen` are cleared, `dut_reset` rises the next cycle.
- `restart` in HOLD or RUN is ignored.
- `reset` asserted mid-run returns the block to HOLD regardless of state; no verdict is produced.

## Timing
- Every output is registered; verdict, `running` and `dut_reset` change on the same edge as the state register.
- `dut_reset` is high for exactly RESET_CYCLES cycles after `reset` deasserts, and after each accepted `restart`.
- `cycle_count` is 0 on the first RUN cycle. The maximum value visible in RUN is TIMEOUT_CYCLES-1.
- TIMEOUT is entered TIMEOUT_CYCLES cycles after RUN entry.
- Pass latency: an edge on `ch_in` at cycle t sets `ch_seen` at t+1. PASS is entered at t+2 when that edge completes the set.
- `fail_in` high at RUN cycle t → FAIL at t+1. This overrides a pass or timeout condition on the same cycle.
- Counter wrap is impossible because of the CNT_W constraint. Toggle counters saturate and never wrap.

## Structure
- Shared package `harness_pkg`:
  - State enum `harness_state_e` (HOLD, RUN, PASS, FAIL, TIMEOUT).
  - Verdict enum, so bench code can decode `{pass, fail, timeout}`.
- Sub-module `edge_toggle_counter`: one instance per channel (generate loop). Parameter MIN_TOGGLES. It contains the previous-value register, the saturating counter and the `seen` flag, with a clear input driven by HOLD.
- The top level holds the FSM, the hold counter and the cycle counter.

## Test plan
- Reset release, defaults, `ch_in` constant 0 → `dut_reset` high exactly 10 cycles. `running` rises in the same cycle `dut_reset` falls. TIMEOUT is entered at RUN cycle 10000; `cycle_count`=9999, `timeout`=1, `pass`=0.
- NUM_CH=4, each channel toggled twice by RUN cycle 50, last edge at cycle 50 → `ch_seen`=4'hF at 51, PASS at 52, `cycle_count` frozen at 51.
- `fail_in` pulsed at RUN cycle 20 while all channels complete on the same cycle → FAIL, `pass`=0; `fail_in` at cycle 0 of HOLD is ignored.
- `ch_in` held at 1 through HOLD, then constant → no edges counted, `ch_seen`=0, ends in TIMEOUT.
- After PASS, `restart` pulse → next cycle `dut_reset`=1 and `done`=0, counters cleared, full run repeats. A `restart` pulse during RUN has no effect.
- `reset` asserted at RUN cycle 500 for one cycle → next cycle HOLD, all outputs at reset values, 10-cycle hold restarts.
